// File: rtl/io_panel_ctrl_pkg.sv
// rtl/io_panel_ctrl_pkg.sv - shared state codes, blank constants and hex-to-segment table for the IO panel
package io_panel_ctrl_pkg;

    typedef enum logic {
        P_IOP_BLANK = 1'b0,
        P_IOP_SHOW  = 1'b1
    } iop_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [2:0] AN_OFF  = 3'b111;

    // Segment order {g,f,e,d,c,b,a}, active low.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/io_panel_ctrl_if.sv
// rtl/io_panel_ctrl_if.sv - pad-side and processor-side signals of the IO panel controller
interface io_panel_ctrl_if;
    logic [15:0] sw_raw;
    logic [11:0] ioout;
    logic [15:0] ioin;
    logic [6:0]  seg;
    logic [2:0]  an;

    modport master (output sw_raw, output ioout, input ioin, input seg, input an);
    modport slave  (input sw_raw, input ioout, output ioin, output seg, output an);
endinterface

// File: rtl/io_debouncer.sv
// rtl/io_debouncer.sv - 2-flop synchronizer, shared sample prescaler and 3-sample debounce per bit
module io_debouncer #(
    parameter int WIDTH    = 16,
    parameter int DEB_TICK = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] q
);
    localparam int            TW        = (DEB_TICK > 1) ? $clog2(DEB_TICK) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DEB_TICK - 1);

    logic [WIDTH-1:0] sync1, sync2;
    logic [WIDTH-1:0] hist0, hist1;
    logic [WIDTH-1:0] agree;
    logic [TW-1:0]    tick_cnt;
    logic             tick;

    assign tick = (tick_cnt == TICK_LAST);

    // The 3-deep history is the incoming synced sample plus the two stored ones,
    // so ioin moves on the same tick the third matching sample arrives.
    assign agree = ~(sync2 ^ hist0) & ~(hist0 ^ hist1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            hist0    <= '0;
            hist1    <= '0;
            tick_cnt <= '0;
            q        <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                hist0 <= sync2;
                hist1 <= hist0;
                q     <= (q & ~agree) | (sync2 & agree);
            end
        end
    end
endmodule

// File: rtl/io_panel_ctrl.sv
// rtl/io_panel_ctrl.sv - switch debounce and 3-digit multiplexed hex display; IOP_LEAD_ZERO_BLANK_EN blanks leading zeros
module io_panel_ctrl
    import io_panel_ctrl_pkg::*;
#(
    parameter int DEB_TICK     = 50000,
    parameter int SCAN_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input logic           clk,
    input logic           rst,
    io_panel_ctrl_if.slave bus
);
    localparam int            MAXC       = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
    localparam int            CW         = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    iop_state_t  state;
    logic [CW-1:0] cnt;
    logic [1:0]  digit, next_digit;
    logic [11:0] disp_q;
    logic [3:0]  nib;
    logic        lead_blank;
    logic [6:0]  digit_seg, seg_q;
    logic [2:0]  an_q;

    io_debouncer #(
        .WIDTH   (16),
        .DEB_TICK(DEB_TICK)
    ) u_deb (
        .clk(clk),
        .rst(rst),
        .raw(bus.sw_raw),
        .q  (bus.ioin)
    );

    always_comb begin
        next_digit = (digit == 2'd2) ? 2'd0 : digit + 2'd1;
        case (digit)
            2'd0:    nib = disp_q[3:0];
            2'd1:    nib = disp_q[7:4];
            default: nib = disp_q[11:8];
        endcase
`ifdef IOP_LEAD_ZERO_BLANK_EN
        lead_blank = ((digit == 2'd2) && (disp_q[11:8] == 4'h0)) ||
                     ((digit == 2'd1) && (disp_q[11:4] == 8'h00));
`else
        lead_blank = 1'b0;
`endif
        digit_seg = lead_blank ? SEG_OFF : hex_to_seg(nib);
    end

    // Every digit is preceded by a gap with all anodes off, so at most one anode is ever low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= P_IOP_BLANK;
            cnt    <= '0;
            digit  <= 2'd0;
            disp_q <= '0;
            seg_q  <= SEG_OFF;
            an_q   <= AN_OFF;
        end else begin
            case (state)
                P_IOP_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt   <= '0;
                        state <= P_IOP_SHOW;
                        an_q  <= ~(3'b001 << digit);
                        seg_q <= digit_seg;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == SCAN_LAST) begin
                        cnt   <= '0;
                        state <= P_IOP_BLANK;
                        an_q  <= AN_OFF;
                        seg_q <= SEG_OFF;
                        digit <= next_digit;
                        // Snapshot once per frame so a frame never mixes two ioout words.
                        if (next_digit == 2'd0) begin
                            disp_q <= bus.ioout;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
endmodule

// File: tb/tb_io_panel_ctrl.sv
// tb/tb_io_panel_ctrl.sv - randomized bench for io_panel_ctrl against a cycle-count reference model
module tb_io_panel_ctrl;
    localparam int DT    = 4;
    localparam int SC    = 8;
    localparam int BC    = 2;
    localparam int PER   = SC + BC;
    localparam int FRAME = 3 * PER;

    logic clk = 1'b0;
    logic rst = 1'b1;

    io_panel_ctrl_if bus ();

    io_panel_ctrl #(
        .DEB_TICK    (DT),
        .SCAN_CYCLES (SC),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state: edge count since reset release, raw delay line,
    // last two tick samples, expected ioin and the word shown in the current frame.
    int          k;
    int          t;
    logic [15:0] raw_d1, raw_d2, smp, s_a, s_b, agree;
    logic [15:0] m_ioin;
    logic [11:0] m_word;
    logic        chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (k=%0d)", nm, act, exp, k);
        end
    endtask

    function automatic void expect_disp(input int kk, input logic [11:0] w,
                                        output logic [2:0] an_e, output logic [6:0] seg_e);
        int tt;
        int d;
        tt    = kk - BC;
        an_e  = 3'b111;
        seg_e = 7'h7F;
        if (tt >= 0 && (tt % PER) < SC) begin
            d       = (tt / PER) % 3;
            an_e[d] = 1'b0;
            seg_e   = hex_tab[w[4*d +: 4]];
`ifdef IOP_LEAD_ZERO_BLANK_EN
            if ((d == 2 && w[11:8] == 4'h0) || (d == 1 && w[11:4] == 8'h00)) seg_e = 7'h7F;
`endif
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k = 0; raw_d1 = '0; raw_d2 = '0; s_a = '0; s_b = '0; m_ioin = '0; m_word = '0;
        end else begin
            k++;
            smp    = raw_d2;
            raw_d2 = raw_d1;
            raw_d1 = bus.sw_raw;
            if (k % DT == 0) begin
                agree  = ~(smp ^ s_a) & ~(s_a ^ s_b);
                m_ioin = (m_ioin & ~agree) | (smp & agree);
                s_b    = s_a;
                s_a    = smp;
            end
            t = k - BC;
            if (t >= 0 && (t % FRAME) == FRAME - BC) m_word = bus.ioout;
        end
    end

    always @(negedge clk) begin
        logic [2:0] ae;
        logic [6:0] se;
        if (chk_en) begin
            expect_disp(k, m_word, ae, se);
            check("ioin", bus.ioin, m_ioin);
            check("an", bus.an, ae);
            check("seg", bus.seg, se);
            check("one_anode", ($countones(~bus.an) <= 1), 1);
        end
    end

    task automatic wait_phase(input int p);
        bit hit;
        hit = 0;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            @(negedge clk);
            if (k >= BC && ((k - BC) % FRAME) == p) begin
                hit = 1;
                break;
            end
        end
        check("wait_phase", hit, 1);
    endtask

    initial begin
        bit found;
        logic [6:0] lz_exp [3];
        bus.sw_raw = '0;
        bus.ioout  = 12'hA5C;
        rst        = 1'b1;

        // Reset values and first SHOW latency.
        repeat (3) @(negedge clk);
        check("rst_ioin", bus.ioin, 16'h0000);
        check("rst_an", bus.an, 3'b111);
        check("rst_seg", bus.seg, 7'h7F);
        chk_en = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        check("gap_k1_an", bus.an, 3'b111);
        @(negedge clk);
        check("first_show_an", bus.an, 3'b110);

        // Second frame shows the A5C snapshot: C, 5, A with 8-cycle digits and 2-cycle gaps.
        wait_phase(0);
        check("a5c_d0_seg", bus.seg, 7'h46);
        check("a5c_d0_an", bus.an, 3'b110);
        repeat (7) @(negedge clk);
        check("a5c_d0_last", bus.an, 3'b110);
        @(negedge clk);
        check("a5c_gap", bus.an, 3'b111);
        wait_phase(10);
        check("a5c_d1_seg", bus.seg, 7'h12);
        check("a5c_d1_an", bus.an, 3'b101);
        wait_phase(20);
        check("a5c_d2_seg", bus.seg, 7'h08);
        check("a5c_d2_an", bus.an, 3'b011);

        // Debounce latency: both bits land together within 14 cycles.
        bus.sw_raw = 16'h8001;
        found = 0;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (bus.ioin != 16'h0000) begin
                found = 1;
                break;
            end
        end
        check("deb_seen", found, 1);
        check("deb_8001", bus.ioin, 16'h8001);
        repeat (10) @(negedge clk);
        bus.sw_raw = 16'h0000;
        repeat (20) @(negedge clk);
        check("deb_back0", bus.ioin, 16'h0000);

        // Short pulses never pass.
        repeat (5) begin
            bus.sw_raw = 16'h0008;
            repeat (3) @(negedge clk);
            bus.sw_raw = 16'h0000;
            repeat (17) @(negedge clk);
            check("glitch", bus.ioin, 16'h0000);
        end

        // Frame coherence: change mid digit 1, remainder still the old word.
        bus.ioout = 12'h123;
        wait_phase(0);
        wait_phase(0);
        wait_phase(14);
        bus.ioout = 12'h456;
        wait_phase(20);
        check("coh_d2_old", bus.seg, 7'h79);
        wait_phase(0);
        check("coh_d0_new", bus.seg, 7'h02);
        wait_phase(10);
        check("coh_d1_new", bus.seg, 7'h12);
        wait_phase(20);
        check("coh_d2_new", bus.seg, 7'h19);

        // Leading zeros.
`ifdef IOP_LEAD_ZERO_BLANK_EN
        lz_exp = '{7'h78, 7'h7F, 7'h7F};
`else
        lz_exp = '{7'h78, 7'h40, 7'h40};
`endif
        bus.ioout = 12'h007;
        wait_phase(0);
        wait_phase(0);
        check("lz_d0", bus.seg, lz_exp[0]);
        wait_phase(10);
        check("lz_d1", bus.seg, lz_exp[1]);
        check("lz_d1_an", bus.an, 3'b101);
        wait_phase(20);
        check("lz_d2", bus.seg, lz_exp[2]);
        check("lz_d2_an", bus.an, 3'b011);

        // Randomized traffic with one asynchronous reset in the middle.
        for (int seg_i = 0; seg_i < 200; seg_i++) begin
            if ($urandom_range(0, 3) == 0) bus.ioout = 12'($urandom);
            if ($urandom_range(0, 3) == 0) bus.sw_raw = 16'($urandom);
            else bus.sw_raw = bus.sw_raw ^ (16'h0001 << $urandom_range(0, 15));
            repeat ($urandom_range(1, 25)) @(negedge clk);
            if (seg_i == 100) begin
                #2 rst = 1'b1;
                #1;
                check("arst_ioin", bus.ioin, 16'h0000);
                check("arst_an", bus.an, 3'b111);
                check("arst_seg", bus.seg, 7'h7F);
                repeat (2) @(negedge clk);
                rst = 1'b0;
                repeat (2) @(negedge clk);
                check("arst_first_show", bus.an, 3'b110);
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
